// File: rtl/seg_reader.sv
// Captures six active-low 7-segment patterns on start and streams their decoded
// nibbles out one at a time over a valid/ready handshake.
module seg_reader #(
  parameter int MSB_FIRST = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [6:0] hex0,
  input  logic [6:0] hex1,
  input  logic [6:0] hex2,
  input  logic [6:0] hex3,
  input  logic [6:0] hex4,
  input  logic [6:0] hex5,
  output logic [3:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       err,
  output logic [2:0] cnt,
  output logic       busy,
  output logic       done
);

  // state | meaning
  // IDLE  | waiting for start; snapshot taken on acceptance
  // LOAD  | decoding the indexed digit into the output registers
  // SEND  | presenting the digit until the consumer takes it
  typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;

  localparam logic [2:0] FIRST_IDX = (MSB_FIRST != 0) ? 3'd5 : 3'd0;
  localparam logic [2:0] LAST_IDX  = (MSB_FIRST != 0) ? 3'd0 : 3'd5;

  state_t           state_q, state_d;
  logic [5:0][6:0]  snap_q, snap_d;
  logic [2:0]       idx_q, idx_d;
  logic [3:0]       data_q, data_d;
  logic             err_q, err_d;
  logic [2:0]       cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Returns {err, nibble}; unknown patterns give nibble 0 with err set.
  function automatic logic [4:0] seg_decode(input logic [6:0] seg);
    logic [4:0] r;
    case (seg)
      7'h40:   r = 5'h00;
      7'h79:   r = 5'h01;
      7'h24:   r = 5'h02;
      7'h30:   r = 5'h03;
      7'h19:   r = 5'h04;
      7'h12:   r = 5'h05;
      7'h02:   r = 5'h06;
      7'h78:   r = 5'h07;
      7'h00:   r = 5'h08;
      7'h10:   r = 5'h09;
      7'h08:   r = 5'h0A;
      7'h03:   r = 5'h0B;
      7'h46:   r = 5'h0C;
      7'h21:   r = 5'h0D;
      7'h06:   r = 5'h0E;
      7'h0E:   r = 5'h0F;
      default: r = 5'h10;
    endcase
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    idx_d   = idx_q;
    data_d  = data_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          snap_d  = {hex5, hex4, hex3, hex2, hex1, hex0};
          idx_d   = FIRST_IDX;
          busy_d  = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        {err_d, data_d} = seg_decode(snap_q[idx_q]);
        cnt_d   = idx_q;
        valid_d = 1'b1;
        state_d = SEND;
      end
      SEND: begin
        if (ready) begin
          valid_d = 1'b0;
          if (idx_q == LAST_IDX) begin
            busy_d  = 1'b0;
            cnt_d   = 3'd0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            // The step is only taken away from the last position, so idx stays in 0..5.
            idx_d   = (MSB_FIRST != 0) ? idx_q - 3'd1 : idx_q + 3'd1;
            state_d = LOAD;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      snap_q  <= '0;
      idx_q   <= 3'd0;
      data_q  <= 4'd0;
      err_q   <= 1'b0;
      cnt_q   <= 3'd0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign data  = data_q;
  assign err   = err_q;
  assign cnt   = cnt_q;
  assign valid = valid_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_seg_reader.sv
// Randomized bench for seg_reader: both digit orders, stalls, input changes and
// resets mid-transfer, checked against a table-lookup reference model.
module tb_seg_reader;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic       ready;
  logic [6:0] hex [6];

  logic [3:0] d0_data, d1_data;
  logic       d0_valid, d1_valid, d0_err, d1_err, d0_busy, d1_busy, d0_done, d1_done;
  logic [2:0] d0_cnt, d1_cnt;

  bit         sel_lsb;
  logic [3:0] m_data;
  logic       m_valid, m_err, m_busy, m_done;
  logic [2:0] m_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  seg_reader #(.MSB_FIRST(1)) u_msb (
    .clock(clock), .reset(reset), .start(start),
    .hex0(hex[0]), .hex1(hex[1]), .hex2(hex[2]), .hex3(hex[3]), .hex4(hex[4]), .hex5(hex[5]),
    .data(d0_data), .valid(d0_valid), .ready(ready), .err(d0_err), .cnt(d0_cnt),
    .busy(d0_busy), .done(d0_done)
  );

  seg_reader #(.MSB_FIRST(0)) u_lsb (
    .clock(clock), .reset(reset), .start(start),
    .hex0(hex[0]), .hex1(hex[1]), .hex2(hex[2]), .hex3(hex[3]), .hex4(hex[4]), .hex5(hex[5]),
    .data(d1_data), .valid(d1_valid), .ready(ready), .err(d1_err), .cnt(d1_cnt),
    .busy(d1_busy), .done(d1_done)
  );

  assign m_data  = sel_lsb ? d1_data  : d0_data;
  assign m_valid = sel_lsb ? d1_valid : d0_valid;
  assign m_err   = sel_lsb ? d1_err   : d0_err;
  assign m_cnt   = sel_lsb ? d1_cnt   : d0_cnt;
  assign m_busy  = sel_lsb ? d1_busy  : d0_busy;
  assign m_done  = sel_lsb ? d1_done  : d0_done;

  // Reference code table: codes[n] is the pattern that shows nibble n.
  logic [6:0] codes [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic [6:0] snap_exp [6];
  logic [3:0] e_data [$];
  logic       e_err  [$];
  logic [2:0] e_cnt  [$];

  logic [3:0] o_data [$];
  logic       o_err  [$];
  logic [2:0] o_cnt  [$];
  int  o_done_k, o_done_pulses, o_post_busy, hold_viol;
  bit  o_timeout;
  int  stall_digit, stall_len;
  bit  perturb, rand_ready;

  function automatic logic [4:0] model_dec(input logic [6:0] p);
    for (int i = 0; i < 16; i++)
      if (codes[i] == p) return {1'b0, 4'(i)};
    return 5'b10000;
  endfunction

  task automatic take_snapshot();
    for (int i = 0; i < 6; i++) snap_exp[i] = hex[i];
  endtask

  task automatic build_expected(input bit lsb_first);
    int pos;
    logic [4:0] r;
    e_data.delete(); e_err.delete(); e_cnt.delete();
    for (int j = 0; j < 6; j++) begin
      pos = lsb_first ? j : 5 - j;
      r = model_dec(snap_exp[pos]);
      e_data.push_back(r[3:0]);
      e_err.push_back(r[4]);
      e_cnt.push_back(3'(pos));
    end
  endtask

  task automatic rand_hex();
    for (int i = 0; i < 6; i++)
      hex[i] = ($urandom_range(0, 3) == 0) ? 7'($urandom) : codes[$urandom_range(0, 15)];
  endtask

  // Pulses start, plays the consumer, and records every accepted digit.
  task automatic run_xfer();
    int k, hs, stalled;
    bit prev_stall;
    logic [7:0] prev;
    o_data.delete(); o_err.delete(); o_cnt.delete();
    o_done_k = -1; o_done_pulses = 0; o_post_busy = 0; hold_viol = 0; o_timeout = 0;
    hs = 0; stalled = 0; prev_stall = 0; prev = '0;
    @(negedge clock);
    start = 1'b1;
    ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    k = 0;
    while (k < 400) begin
      @(posedge clock);
      k++;
      @(negedge clock);
      if (perturb && k == 3) begin
        for (int i = 0; i < 6; i++) hex[i] = 7'h08;
        start = 1'b1;
      end else if (perturb && k == 4) start = 1'b0;
      if (m_done) begin
        o_done_pulses++;
        if (o_done_k < 0) o_done_k = k;
      end
      if (o_done_k >= 0 && m_busy) o_post_busy++;
      if (o_done_k >= 0 && k >= o_done_k + 3) break;
      if (m_valid && hs == stall_digit && stalled < stall_len) begin
        ready = 1'b0;
        stalled++;
      end else if (rand_ready) ready = 1'($urandom_range(0, 1));
      else ready = 1'b1;
      if (prev_stall && (!m_valid || {m_data, m_err, m_cnt} != prev)) hold_viol++;
      prev = {m_data, m_err, m_cnt};
      prev_stall = m_valid && !ready;
      if (m_valid && ready) begin
        o_data.push_back(m_data);
        o_err.push_back(m_err);
        o_cnt.push_back(m_cnt);
        hs++;
      end
    end
    if (o_done_k < 0) o_timeout = 1'b1;
    ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; ready = 1'b0;
    for (int i = 0; i < 6; i++) hex[i] = 7'h7F;
    repeat (3) @(posedge clock);
    @(negedge clock);
    n_cmp++;
    if ({d0_data, d0_valid, d0_err, d0_cnt, d0_busy, d0_done} !== 10'd0) begin
      n_bad++;
      $display("FAIL reset_msb: got %b want 0", {d0_data, d0_valid, d0_err, d0_cnt, d0_busy, d0_done});
    end
    n_cmp++;
    if ({d1_data, d1_valid, d1_err, d1_cnt, d1_busy, d1_done} !== 10'd0) begin
      n_bad++;
      $display("FAIL reset_lsb: got %b want 0", {d1_data, d1_valid, d1_err, d1_cnt, d1_busy, d1_done});
    end
    reset = 1'b1;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_digits(input bit lsb_first);
    sel_lsb = lsb_first; stall_digit = -1; stall_len = 0; perturb = 0; rand_ready = 0;
    for (int i = 0; i < 6; i++) hex[i] = codes[i + 1];
    take_snapshot();
    build_expected(lsb_first);
    run_xfer();
    n_cmp++;
    if (o_timeout || o_data.size() != 6) begin
      n_bad++;
      $display("FAIL digits_count lsb=%0d: got %0d digits timeout=%0d want 6", lsb_first, o_data.size(), o_timeout);
    end
    for (int j = 0; j < 6 && j < o_data.size(); j++) begin
      n_cmp++;
      if ({o_data[j], o_err[j], o_cnt[j]} !== {e_data[j], e_err[j], e_cnt[j]}) begin
        n_bad++;
        $display("FAIL digits_seq lsb=%0d #%0d: got d=%h e=%b c=%0d want d=%h e=%b c=%0d", lsb_first, j,
                 o_data[j], o_err[j], o_cnt[j], e_data[j], e_err[j], e_cnt[j]);
      end
    end
    n_cmp++;
    if (o_done_k != 12 || o_done_pulses != 1) begin
      n_bad++;
      $display("FAIL digits_done lsb=%0d: got cycle %0d pulses %0d want cycle 12 pulses 1", lsb_first, o_done_k, o_done_pulses);
    end
  endtask

  task automatic test_blank();
    int nerr;
    sel_lsb = 0; stall_digit = -1; stall_len = 0; perturb = 0; rand_ready = 0;
    for (int i = 0; i < 6; i++) hex[i] = codes[0];
    hex[3] = 7'h7F;
    take_snapshot();
    build_expected(1'b0);
    run_xfer();
    n_cmp++;
    if (o_timeout || o_data.size() != 6) begin
      n_bad++;
      $display("FAIL blank_count: got %0d digits timeout=%0d want 6", o_data.size(), o_timeout);
    end
    nerr = 0;
    for (int j = 0; j < 6 && j < o_data.size(); j++) begin
      if (o_err[j]) nerr++;
      n_cmp++;
      if ({o_data[j], o_err[j], o_cnt[j]} !== {e_data[j], e_err[j], e_cnt[j]}) begin
        n_bad++;
        $display("FAIL blank_seq #%0d: got d=%h e=%b c=%0d want d=%h e=%b c=%0d", j,
                 o_data[j], o_err[j], o_cnt[j], e_data[j], e_err[j], e_cnt[j]);
      end
    end
    n_cmp++;
    if (nerr != 1) begin
      n_bad++;
      $display("FAIL blank_errcount: got %0d want 1", nerr);
    end
  endtask

  task automatic test_stall();
    sel_lsb = 0; stall_digit = 1; stall_len = 5; perturb = 0; rand_ready = 0;
    rand_hex();
    take_snapshot();
    build_expected(1'b0);
    run_xfer();
    stall_digit = -1;
    n_cmp++;
    if (hold_viol != 0) begin
      n_bad++;
      $display("FAIL stall_hold: got %0d changes while stalled want 0", hold_viol);
    end
    n_cmp++;
    if (o_timeout || o_data.size() != 6) begin
      n_bad++;
      $display("FAIL stall_count: got %0d digits timeout=%0d want 6", o_data.size(), o_timeout);
    end
    for (int j = 0; j < 6 && j < o_data.size(); j++) begin
      n_cmp++;
      if ({o_data[j], o_err[j], o_cnt[j]} !== {e_data[j], e_err[j], e_cnt[j]}) begin
        n_bad++;
        $display("FAIL stall_seq #%0d: got d=%h e=%b c=%0d want d=%h e=%b c=%0d", j,
                 o_data[j], o_err[j], o_cnt[j], e_data[j], e_err[j], e_cnt[j]);
      end
    end
    n_cmp++;
    if (o_done_k != 17) begin
      n_bad++;
      $display("FAIL stall_done: got cycle %0d want 17", o_done_k);
    end
  endtask

  task automatic test_perturb();
    sel_lsb = 0; stall_digit = -1; stall_len = 0; perturb = 1; rand_ready = 0;
    for (int i = 0; i < 6; i++) hex[i] = codes[i + 1];
    take_snapshot();
    build_expected(1'b0);
    run_xfer();
    perturb = 0;
    n_cmp++;
    if (o_timeout || o_data.size() != 6) begin
      n_bad++;
      $display("FAIL perturb_count: got %0d digits timeout=%0d want 6", o_data.size(), o_timeout);
    end
    for (int j = 0; j < 6 && j < o_data.size(); j++) begin
      n_cmp++;
      if ({o_data[j], o_err[j], o_cnt[j]} !== {e_data[j], e_err[j], e_cnt[j]}) begin
        n_bad++;
        $display("FAIL perturb_seq #%0d: got d=%h e=%b c=%0d want d=%h e=%b c=%0d", j,
                 o_data[j], o_err[j], o_cnt[j], e_data[j], e_err[j], e_cnt[j]);
      end
    end
    n_cmp++;
    if (o_post_busy != 0 || o_done_pulses != 1) begin
      n_bad++;
      $display("FAIL perturb_requeue: got busy-after-done %0d done pulses %0d want 0 and 1", o_post_busy, o_done_pulses);
    end
  endtask

  // First three passes sweep every table entry plus two unknown codes; the rest are random.
  task automatic test_table_random();
    for (int t = 0; t < 7; t++) begin
      sel_lsb = (t < 3) ? t[0] : 1'($urandom_range(0, 1));
      stall_digit = -1; stall_len = 0; perturb = 0;
      rand_ready = (t >= 3);
      if (t < 3) begin
        for (int i = 0; i < 6; i++)
          hex[i] = (6 * t + i < 16) ? codes[6 * t + i] : 7'(7'h7F - (6 * t + i));
      end else rand_hex();
      take_snapshot();
      build_expected(sel_lsb);
      run_xfer();
      n_cmp++;
      if (o_timeout || o_data.size() != 6) begin
        n_bad++;
        $display("FAIL table_count t=%0d: got %0d digits timeout=%0d want 6", t, o_data.size(), o_timeout);
      end
      for (int j = 0; j < 6 && j < o_data.size(); j++) begin
        n_cmp++;
        if ({o_data[j], o_err[j], o_cnt[j]} !== {e_data[j], e_err[j], e_cnt[j]}) begin
          n_bad++;
          $display("FAIL table_seq t=%0d #%0d: got d=%h e=%b c=%0d want d=%h e=%b c=%0d", t, j,
                   o_data[j], o_err[j], o_cnt[j], e_data[j], e_err[j], e_cnt[j]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int hs, n_done;
    bit found;
    sel_lsb = 0; stall_digit = -1; stall_len = 0; perturb = 0; rand_ready = 0;
    rand_hex();
    @(negedge clock);
    start = 1'b1; ready = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    hs = 0; found = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clock);
      if (m_valid) begin
        if (hs == 3) found = 1;
        else hs++;
      end
    end
    n_cmp++;
    if (!found) begin
      n_bad++;
      $display("FAIL abort_reach: fourth digit not seen, got %0d handshakes want 3", hs);
    end
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({m_data, m_valid, m_err, m_cnt, m_busy, m_done} !== 10'd0) begin
      n_bad++;
      $display("FAIL abort_zero: got %b want 0", {m_data, m_valid, m_err, m_cnt, m_busy, m_done});
    end
    n_done = 0;
    repeat (2) begin
      @(negedge clock);
      if (m_done) n_done++;
    end
    reset = 1'b1;
    repeat (5) begin
      @(negedge clock);
      if (m_done) n_done++;
    end
    n_cmp++;
    if (n_done != 0 || m_busy !== 1'b0 || m_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_idle: got done pulses %0d busy %b valid %b want 0 0 0", n_done, m_busy, m_valid);
    end
    rand_hex();
    take_snapshot();
    build_expected(1'b0);
    run_xfer();
    n_cmp++;
    if (o_timeout || o_data.size() != 6) begin
      n_bad++;
      $display("FAIL abort_restart_count: got %0d digits timeout=%0d want 6", o_data.size(), o_timeout);
    end
    for (int j = 0; j < 6 && j < o_data.size(); j++) begin
      n_cmp++;
      if ({o_data[j], o_err[j], o_cnt[j]} !== {e_data[j], e_err[j], e_cnt[j]}) begin
        n_bad++;
        $display("FAIL abort_restart_seq #%0d: got d=%h e=%b c=%0d want d=%h e=%b c=%0d", j,
                 o_data[j], o_err[j], o_cnt[j], e_data[j], e_err[j], e_cnt[j]);
      end
    end
  endtask

  task automatic test_start_held();
    bit found;
    sel_lsb = 1; ready = 1'b1;
    rand_hex();
    @(negedge clock);
    start = 1'b1;
    found = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clock);
      if (m_done) found = 1;
    end
    n_cmp++;
    if (!found) begin
      n_bad++;
      $display("FAIL held_done: got no done within 40 cycles want one");
    end
    @(negedge clock);
    n_cmp++;
    if (m_busy !== 1'b1 || m_done !== 1'b0) begin
      n_bad++;
      $display("FAIL held_restart: got busy %b done %b want 1 0", m_busy, m_done);
    end
    start = 1'b0;
    found = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clock);
      if (m_done) found = 1;
    end
    n_cmp++;
    if (!found) begin
      n_bad++;
      $display("FAIL held_second_done: got no done within 40 cycles want one");
    end
    ready = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  initial begin
    sel_lsb = 0; stall_digit = -1; stall_len = 0; perturb = 0; rand_ready = 0;
    test_reset();
    test_digits(1'b0);
    test_digits(1'b1);
    test_blank();
    test_stall();
    test_perturb();
    test_table_random();
    test_reset_mid();
    test_start_held();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
